// File: rtl/soc_gpio_pad_ctrl_if.sv
// SoC GPIO bus between the GPIO peripheral (master) and the pad controller (slave).
interface soc_gpio_bus;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] oe_n;
  logic        irq;

  modport master (input din, output dout, output oe_n, output irq);
  modport slave  (output din, input dout, input oe_n, input irq);
endinterface

// File: rtl/soc_gpio_pad_ctrl.sv
// GPIO pad controller: registered pad outputs, per-pad synchroniser + debouncer,
// and a retriggerable pulse stretcher for the external interrupt pin.
module soc_gpio_pad_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic din
);
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;

  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], pad};

  assign s = sync[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    always_ff @(posedge clk or posedge rst)
      if (rst) din <= 1'b0;
      else     din <= s;
  end else begin : g_debounce
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] cnt;

    // Any return to the stable level restarts the count from zero.
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        din <= 1'b0;
        cnt <= '0;
      end else if (s == din) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        din <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
  end
endmodule

module soc_gpio_pad_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int IRQ_STRETCH     = 8
) (
  input  logic             clk,
  input  logic             rst,
  soc_gpio_bus.slave       gpio,
  input  logic [31:0]      pad_in,
  output logic [31:0]      pad_out,
  output logic [31:0]      pad_oe_n,
  output logic             irq_out
);
  localparam int NUM_PADS = 32;

  logic [NUM_PADS-1:0] din_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pad_out  <= '0;
      pad_oe_n <= '1;
    end else begin
      pad_out  <= gpio.dout;
      pad_oe_n <= gpio.oe_n;
    end

  // din reads the pad level regardless of oe_n, so driven pads read back.
  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    soc_gpio_pad_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk (clk),
      .rst (rst),
      .pad (pad_in[i]),
      .din (din_q[i])
    );
  end

  assign gpio.din = din_q;

  if (IRQ_STRETCH == 0) begin : g_irq_pass
    always_ff @(posedge clk or posedge rst)
      if (rst) irq_out <= 1'b0;
      else     irq_out <= gpio.irq;
  end else begin : g_irq_stretch
    localparam int SW = (IRQ_STRETCH < 2) ? 1 : $clog2(IRQ_STRETCH);
    localparam logic [SW-1:0] SCNT_LOAD = SW'(IRQ_STRETCH - 1);
    logic          irq_q;
    logic [SW-1:0] scnt;

    // A rise reloads the window, so back-to-back pulses retrigger the stretch.
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        irq_q   <= 1'b0;
        scnt    <= '0;
        irq_out <= 1'b0;
      end else begin
        irq_q <= gpio.irq;
        if (gpio.irq && !irq_q) begin
          scnt    <= SCNT_LOAD;
          irq_out <= 1'b1;
        end else if (scnt != '0) begin
          scnt    <= scnt - 1'b1;
          irq_out <= 1'b1;
        end else begin
          irq_out <= gpio.irq;
        end
      end
  end
endmodule

// File: tb/tb_soc_gpio_pad_ctrl.sv
// Directed bench for soc_gpio_pad_ctrl: default build plus a debounce-bypass build.
module tb_soc_gpio_pad_ctrl;
  logic        clk;
  logic        rst;
  logic [31:0] pad_in, pad_in_b;
  logic [31:0] pad_out, pad_oe_n, pad_out_b, pad_oe_n_b;
  logic        irq_out, irq_out_b;
  int          checks;
  int          errors;

  soc_gpio_bus bus ();
  soc_gpio_bus bus_b ();

  soc_gpio_pad_ctrl u_dut (
    .clk      (clk),
    .rst      (rst),
    .gpio     (bus.slave),
    .pad_in   (pad_in),
    .pad_out  (pad_out),
    .pad_oe_n (pad_oe_n),
    .irq_out  (irq_out)
  );

  soc_gpio_pad_ctrl #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(0)) u_byp (
    .clk      (clk),
    .rst      (rst),
    .gpio     (bus_b.slave),
    .pad_in   (pad_in_b),
    .pad_out  (pad_out_b),
    .pad_oe_n (pad_oe_n_b),
    .irq_out  (irq_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.dout = 32'hA5A5_A5A5; bus.oe_n = 32'h0; bus.irq = 1'b0;
    bus_b.dout = 32'h0; bus_b.oe_n = 32'hFFFF_FFFF; bus_b.irq = 1'b0;
    pad_in = 32'hFFFF_FFFF; pad_in_b = 32'h0; rst = 1'b0;
    repeat (3) tick;
    rst = 1'b1;
    #1;
    checks++; if (pad_oe_n !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_oe_n got %h exp ffffffff", pad_oe_n); end
    checks++; if (pad_out !== 32'h0) begin errors++; $display("FAIL rst_pad_out got %h exp 0", pad_out); end
    checks++; if (bus.din !== 32'h0) begin errors++; $display("FAIL rst_din got %h exp 0", bus.din); end
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq_out); end
    checks++; if (bus_b.din !== 32'h0) begin errors++; $display("FAIL rst_din_byp got %h exp 0", bus_b.din); end
    tick; tick;
    checks++; if (pad_out !== 32'h0 || pad_oe_n !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL rst_hold got %h/%h exp 0/ffffffff", pad_out, pad_oe_n);
    end
    pad_in = 32'h0;
    rst = 1'b0;
  endtask

  task automatic test_output;
    bus.dout = 32'h1234_5678; bus.oe_n = 32'hFFFF_0000;
    #1;
    checks++; if (pad_out !== 32'h0 || pad_oe_n !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL out_pre got %h/%h exp 0/ffffffff", pad_out, pad_oe_n);
    end
    tick;
    checks++; if (pad_out !== 32'h1234_5678 || pad_oe_n !== 32'hFFFF_0000) begin
      errors++; $display("FAIL out_lat1 got %h/%h exp 12345678/ffff0000", pad_out, pad_oe_n);
    end
    bus.dout = 32'hDEAD_BEEF; bus.oe_n = 32'h0000_FFFF;
    #1;
    checks++; if (pad_out !== 32'h1234_5678) begin errors++; $display("FAIL out_hold got %h exp 12345678", pad_out); end
    tick;
    checks++; if (pad_out !== 32'hDEAD_BEEF || pad_oe_n !== 32'h0000_FFFF) begin
      errors++; $display("FAIL out_lat2 got %h/%h exp deadbeef/0000ffff", pad_out, pad_oe_n);
    end
  endtask

  task automatic test_clean_edge;
    logic [31:0] exp;
    pad_in = 32'h0000_0008;
    for (int j = 0; j <= 5; j++) begin
      tick;
      exp = (j >= 5) ? 32'h8 : 32'h0;
      checks++; if (bus.din !== exp) begin errors++; $display("FAIL clean_edge%0d got %h exp %h", j, bus.din, exp); end
    end
  endtask

  task automatic test_glitch;
    logic [31:0] exp;
    for (int j = 0; j <= 9; j++) begin
      pad_in[0] = (j < 3 || j >= 4);
      tick;
      exp = (j >= 9) ? 32'h9 : 32'h8;
      checks++; if (bus.din !== exp) begin errors++; $display("FAIL glitch%0d got %h exp %h", j, bus.din, exp); end
    end
  endtask

  task automatic test_bypass;
    logic [31:0] exp;
    pad_in_b = 32'h8000_0001;
    for (int j = 0; j <= 3; j++) begin
      tick;
      exp = (j >= 3) ? 32'h8000_0001 : 32'h0;
      checks++; if (bus_b.din !== exp) begin errors++; $display("FAIL byp_rise%0d got %h exp %h", j, bus_b.din, exp); end
    end
    pad_in_b = 32'h0;
    for (int j = 0; j <= 3; j++) begin
      tick;
      exp = (j >= 3) ? 32'h0 : 32'h8000_0001;
      checks++; if (bus_b.din !== exp) begin errors++; $display("FAIL byp_fall%0d got %h exp %h", j, bus_b.din, exp); end
    end
  endtask

  task automatic test_irq_stretch;
    logic exp;
    bus.irq = 1'b0;
    repeat (3) tick;
    for (int j = 0; j <= 10; j++) begin
      bus.irq = (j == 0);
      tick;
      exp = (j < 8);
      checks++; if (irq_out !== exp) begin errors++; $display("FAIL irq_pulse%0d got %b exp %b", j, irq_out, exp); end
    end
  endtask

  task automatic test_irq_retrigger;
    logic exp;
    bus.irq = 1'b0;
    repeat (3) tick;
    for (int j = 0; j <= 15; j++) begin
      bus.irq = (j == 0 || j == 5);
      tick;
      exp = (j < 13);
      checks++; if (irq_out !== exp) begin errors++; $display("FAIL irq_retrig%0d got %b exp %b", j, irq_out, exp); end
    end
  endtask

  task automatic test_irq_held;
    logic exp;
    bus.irq = 1'b0;
    repeat (3) tick;
    for (int j = 0; j <= 22; j++) begin
      bus.irq = (j < 20);
      tick;
      exp = (j < 20);
      checks++; if (irq_out !== exp) begin errors++; $display("FAIL irq_held%0d got %b exp %b", j, irq_out, exp); end
    end
  endtask

  task automatic test_reset_mid;
    bus.dout = 32'h0F0F_0F0F; bus.oe_n = 32'h0;
    pad_in = 32'h0;
    bus.irq = 1'b1; tick;
    bus.irq = 1'b0; tick; tick;
    rst = 1'b1;
    #1;
    checks++; if (bus.din !== 32'h0) begin errors++; $display("FAIL mid_rst_din got %h exp 0", bus.din); end
    checks++; if (pad_oe_n !== 32'hFFFF_FFFF || pad_out !== 32'h0) begin
      errors++; $display("FAIL mid_rst_pads got %h/%h exp 0/ffffffff", pad_out, pad_oe_n);
    end
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL mid_rst_irq got %b exp 0", irq_out); end
    tick;
    rst = 1'b0;
    repeat (6) tick;
    checks++; if (bus.din !== 32'h0 || irq_out !== 1'b0) begin
      errors++; $display("FAIL mid_rst_after got %h/%b exp 0/0", bus.din, irq_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_output;
    test_clean_edge;
    test_glitch;
    test_bypass;
    test_irq_stretch;
    test_irq_retrigger;
    test_irq_held;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
